// File: rtl/parity_pkg.sv
// Shared definitions for the parity scan controller: FSM encoding, the
// odd-popcount decoder mask and the chunk-count helper.
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Decoder lines 1, 2, 4 and 7 carry an odd number of ones in their index.
    localparam logic [7:0] ODD_MASK = 8'b1001_0110;

    function automatic int nchunk(input int width);
        return (width + 2) / 3;
    endfunction

endpackage

// File: rtl/parity_scan_ctrl_decoder_3to8.sv
// Plain 3-to-8 one-hot decoder shared by the parity scan controller.
module decoder_3to8 (
    input  logic [2:0] a,
    output logic [7:0] y
);

    always_comb begin
        y    = '0;
        y[a] = 1'b1;
    end

endmodule

// File: rtl/parity_scan_ctrl.sv
// Generates or checks odd parity on a word by walking it 3 bits per clock
// through a single 3-to-8 decoder and accumulating per-chunk parity.
module parity_scan_ctrl
    import parity_pkg::*;
#(
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_par,
    input  logic              in_check,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_par,
    output logic              out_err,
    output logic              busy,
    output state_t            dbg_state
);

    // Handshake: a word or result transfers on a rising clk edge where
    // valid && ready; valid is held by the source until that edge, and
    // in_valid outside IDLE is simply not looked at.

    localparam int NCHUNK = nchunk(DATA_W);
    localparam int WORD_W = 3 * NCHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    state_t            state_q, state_d;
    logic [WORD_W-1:0] word_q;
    logic [IDX_W-1:0]  idx_q;
    logic              acc_q;
    logic              par_q;
    logic              check_q;
    logic              out_par_q;
    logic              out_err_q;
    logic [2:0]        chunk;
    logic [7:0]        dec_y;
    logic              chunk_par;
    logic              acc_next;

    always_comb begin
        chunk = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IDX_W'(i)) begin
                chunk = word_q[3*i +: 3];
            end
        end
    end

    decoder_3to8 u_dec (
        .a (chunk),
        .y (dec_y)
    );

    assign chunk_par = |(dec_y & ODD_MASK);
    assign acc_next  = acc_q ^ chunk_par;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = SCAN;
            SCAN:    if (idx_q == LAST_IDX) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            word_q    <= '0;
            idx_q     <= '0;
            acc_q     <= 1'b0;
            par_q     <= 1'b0;
            check_q   <= 1'b0;
            out_par_q <= 1'b0;
            out_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        // Zero padding of the top chunk leaves parity unchanged.
                        word_q  <= WORD_W'(in_data);
                        par_q   <= in_par;
                        check_q <= in_check;
                        acc_q   <= 1'b0;
                        idx_q   <= '0;
                    end
                end
                SCAN: begin
                    acc_q <= acc_next;
                    if (idx_q == LAST_IDX) begin
                        out_par_q <= ~acc_next;
                        out_err_q <= check_q & ~(acc_next ^ par_q);
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_par   = out_par_q;
    assign out_err   = out_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_parity_scan_ctrl.sv
// Self-checking bench for parity_scan_ctrl: scoreboard-checked 12-bit instance
// plus a small directed run on an 8-bit (padded) instance.
module tb_parity_scan_ctrl;
    import parity_pkg::*;

    localparam int W   = 12;
    localparam int N12 = 4;
    localparam int N8  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          a_in_valid, a_in_ready, a_in_par, a_in_check;
    logic [W-1:0]  a_in_data;
    logic          a_out_valid, a_out_ready, a_out_par, a_out_err, a_busy;
    state_t        a_state;

    logic          b_in_valid, b_in_ready, b_in_par, b_in_check;
    logic [7:0]    b_in_data;
    logic          b_out_valid, b_out_ready, b_out_par, b_out_err, b_busy;
    state_t        b_state;

    parity_scan_ctrl #(.DATA_W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .in_par(a_in_par), .in_check(a_in_check),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_par(a_out_par), .out_err(a_out_err),
        .busy(a_busy), .dbg_state(a_state)
    );

    parity_scan_ctrl #(.DATA_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_par(b_in_par), .in_check(b_in_check),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_par(b_out_par), .out_err(b_out_err),
        .busy(b_busy), .dbg_state(b_state)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic par;
        logic err;
        int   acc_cyc;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: odd parity bit makes the total count of ones odd.
    function automatic logic ref_par(input logic [31:0] d);
        return ($countones(d) % 2) == 0;
    endfunction

    function automatic logic ref_err(input logic [31:0] d, input logic p, input logic c);
        return c && ((($countones(d) + int'(p)) % 2) == 0);
    endfunction

    task automatic send(input logic [W-1:0] d, input logic p, input logic c, output int acc_at);
        int n;
        n = 0;
        @(negedge clk);
        a_in_valid = 1'b1;
        a_in_data  = d;
        a_in_par   = p;
        a_in_check = c;
        while (!a_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", {31'd0, a_in_ready}, 32'd1);
        acc_at = cyc + 1;
        exp_q.push_back('{ref_par(32'(d)), ref_err(32'(d), p, c), acc_at});
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        a_in_data  = W'($urandom);
        a_in_par   = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || a_busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", {31'd0, (exp_q.size() == 0 && !a_busy)}, 32'd1);
    endtask

    logic prev_ov = 1'b0;
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (a_state == SCAN) begin
                chk("decoder_onehot", {31'd0, $onehot(dut.dec_y)}, 32'd1);
            end
            if (a_out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 32'd1, 32'd0);
                end else begin
                    if (!prev_ov) chk("latency", 32'(cyc - exp_q[0].acc_cyc), N12);
                    chk("out_par", {31'd0, a_out_par}, {31'd0, exp_q[0].par});
                    chk("out_err", {31'd0, a_out_err}, {31'd0, exp_q[0].err});
                    chk("in_ready_in_done", {31'd0, a_in_ready}, 32'd0);
                    if (a_out_ready) exp_q.pop_front();
                end
            end
        end
        prev_ov <= a_out_valid;
    end

    task automatic run8(input logic [7:0] d, input logic req_par);
        int n;
        int t;
        n = 0;
        @(negedge clk);
        b_in_valid = 1'b1;
        b_in_data  = d;
        while (!b_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        t = cyc + 1;
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        #1;
        while (!b_out_valid && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("b_latency", 32'(cyc - t), N8);
        chk("b_out_par", {31'd0, b_out_par}, {31'd0, req_par});
        chk("b_out_par_model", {31'd0, b_out_par}, {31'd0, ref_par(32'(d))});
        chk("b_out_err", {31'd0, b_out_err}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int t_prev;
        rst_n       = 1'b0;
        a_in_valid  = 1'b0;
        a_in_data   = '0;
        a_in_par    = 1'b0;
        a_in_check  = 1'b0;
        a_out_ready = 1'b1;
        b_in_valid  = 1'b0;
        b_in_data   = '0;
        b_in_par    = 1'b0;
        b_in_check  = 1'b0;
        b_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, a_in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
        chk("rst_out_par", {31'd0, a_out_par}, 32'd0);
        chk("rst_out_err", {31'd0, a_out_err}, 32'd0);
        chk("rst_busy", {31'd0, a_busy}, 32'd0);
        chk("rst_state", {30'd0, a_state}, {30'd0, IDLE});
        rst_n = 1'b1;

        // Directed generate and check words.
        send(12'h000, 1'b0, 1'b0, t);
        send(12'h001, 1'b0, 1'b0, t);
        send(12'hFFF, 1'b0, 1'b0, t);
        send(12'h807, 1'b0, 1'b0, t);
        send(12'h007, 1'b0, 1'b1, t);
        send(12'h007, 1'b1, 1'b1, t);
        drain();

        // Backpressure: result must hold while out_ready is low.
        @(negedge clk);
        a_out_ready = 1'b0;
        send(12'h5A3, 1'b1, 1'b1, t);
        for (int n = 0; n < 50 && !a_out_valid; n++) @(negedge clk);
        repeat (5) @(negedge clk);
        chk("bp_valid_held", {31'd0, a_out_valid}, 32'd1);
        a_out_ready = 1'b1;
        @(negedge clk);
        #2;
        chk("bp_idle_after_ready", {31'd0, a_busy}, 32'd0);
        chk("bp_state_idle", {30'd0, a_state}, {30'd0, IDLE});

        // Back-to-back throughput.
        t_prev = 0;
        for (int i = 0; i < 4; i++) begin
            send(W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), t);
            if (i > 0) chk("throughput", 32'(t - t_prev), N12 + 2);
            t_prev = t;
        end
        drain();

        // Reset on the second SCAN clock discards the word.
        send(12'hABC, 1'b1, 1'b1, t);
        @(negedge clk);
        @(negedge clk);
        chk("mid_state_scan", {30'd0, a_state}, {30'd0, SCAN});
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        #2;
        chk("mid_rst_out_valid", {31'd0, a_out_valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, a_busy}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, a_in_ready}, 32'd1);
        rst_n = 1'b1;
        send(12'h003, 1'b0, 1'b0, t);
        drain();

        // Randomized words with idle gaps.
        for (int i = 0; i < 24; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), t);
        end
        drain();

        // Padded 8-bit instance.
        run8(8'hFF, 1'b1);
        run8(8'h80, 1'b0);
        for (int i = 0; i < 6; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            run8(d, ref_par(32'(d)));
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
